// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : raster counters, sync/active decode, delayed syncs and
//                  frame-start / frame-count / blink events.
// Revision: 1.0
// ============================================================================
module vga_timing_gen #(
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int H_ACT      = 640,
    parameter int H_FP       = 16,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int V_ACT      = 480,
    parameter int V_FP       = 10,
    parameter int PIPE_DELAY = 3,
    parameter int BLINK_BIT  = 5
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       pixel_en,
    output logic [9:0] h_addr,
    output logic [9:0] v_addr,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       hsync_d,
    output logic       vsync_d,
    output logic       valid_d,
    output logic       frame_start,
    output logic [7:0] frame_cnt,
    output logic       blink
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

    localparam logic [9:0] c_h_last = 10'(H_TOT - 1);
    localparam logic [9:0] c_v_last = 10'(V_TOT - 1);
    localparam logic [9:0] c_h_sync = 10'(H_SYNC);
    localparam logic [9:0] c_v_sync = 10'(V_SYNC);
    localparam logic [9:0] c_h_beg  = 10'(H_SYNC + H_BP);
    localparam logic [9:0] c_h_end  = 10'(H_SYNC + H_BP + H_ACT);
    localparam logic [9:0] c_v_beg  = 10'(V_SYNC + V_BP);
    localparam logic [9:0] c_v_end  = 10'(V_SYNC + V_BP + V_ACT);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [9:0] h_addr_q, h_addr_d;
    logic [9:0] v_addr_q, v_addr_d;
    logic       act_q, act_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       fs_q, fs_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic       w_h_in, w_v_in;

    assign w_h_in = (h_cnt_q >= c_h_beg) && (h_cnt_q < c_h_end);
    assign w_v_in = (v_cnt_q >= c_v_beg) && (v_cnt_q < c_v_end);

    // Outputs decode the counter pair as it stood before the enabled edge.
    always_comb begin
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        h_addr_d = h_addr_q;
        v_addr_d = v_addr_q;
        act_d    = act_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        fs_d     = 1'b0;
        fcnt_d   = fcnt_q;
        if (pixel_en) begin
            if (h_cnt_q == c_h_last) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            hs_d     = (h_cnt_q >= c_h_sync);
            vs_d     = (v_cnt_q >= c_v_sync);
            act_d    = w_h_in && w_v_in;
            h_addr_d = act_d ? (h_cnt_q - c_h_beg) : '0;
            v_addr_d = act_d ? (v_cnt_q - c_v_beg) : '0;
            fs_d     = (h_cnt_q == '0) && (v_cnt_q == '0);
            if (fs_d) begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            h_addr_q <= '0;
            v_addr_q <= '0;
            act_q    <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            fs_q     <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            h_addr_q <= h_addr_d;
            v_addr_q <= v_addr_d;
            act_q    <= act_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            fs_q     <= fs_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign h_addr      = h_addr_q;
    assign v_addr      = v_addr_q;
    assign valid       = act_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;
    assign blink       = fcnt_q[BLINK_BIT];

    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign hsync_d = hs_q;
            assign vsync_d = vs_q;
            assign valid_d = act_q;
        end else begin : g_pipe
            // Each stage packs {hsync, vsync, valid}; shifts every clk.
            logic [2:0] pipe_q [PIPE_DELAY];
            logic [2:0] pipe_d [PIPE_DELAY];

            always_comb begin
                pipe_d[0] = {hs_q, vs_q, act_q};
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge clrn) begin
                if (!clrn) begin
                    pipe_q <= '{default: 3'b110};
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign hsync_d = pipe_q[PIPE_DELAY-1][2];
            assign vsync_d = pipe_q[PIPE_DELAY-1][1];
            assign valid_d = pipe_q[PIPE_DELAY-1][0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_gen : scoreboard bench on a reduced raster geometry.
// Revision: 1.0
// ============================================================================
module tb_vga_timing_gen;

    localparam int HS  = 4, HBP = 3, HA = 8, HFP = 2;
    localparam int VS  = 2, VBP = 2, VA = 4, VFP = 1;
    localparam int HT  = HS + HBP + HA + HFP;   // 17
    localparam int VT  = VS + VBP + VA + VFP;   // 9
    localparam int FR  = HT * VT;               // 153

    logic clk = 1'b0, clrn = 1'b0, pixel_en = 1'b0;
    logic [9:0] h_addr, v_addr, h_addr0, v_addr0;
    logic valid, hsync, vsync, hsync_d, vsync_d, valid_d, frame_start, blink;
    logic valid0, hsync0, vsync0, hsync_d0, vsync_d0, valid_d0, frame_start0, blink0;
    logic [7:0] frame_cnt, frame_cnt0;

    vga_timing_gen #(.H_SYNC(HS), .H_BP(HBP), .H_ACT(HA), .H_FP(HFP),
                     .V_SYNC(VS), .V_BP(VBP), .V_ACT(VA), .V_FP(VFP),
                     .PIPE_DELAY(3), .BLINK_BIT(5)) dut (
        .clk(clk), .clrn(clrn), .pixel_en(pixel_en),
        .h_addr(h_addr), .v_addr(v_addr), .valid(valid),
        .hsync(hsync), .vsync(vsync),
        .hsync_d(hsync_d), .vsync_d(vsync_d), .valid_d(valid_d),
        .frame_start(frame_start), .frame_cnt(frame_cnt), .blink(blink));

    vga_timing_gen #(.H_SYNC(HS), .H_BP(HBP), .H_ACT(HA), .H_FP(HFP),
                     .V_SYNC(VS), .V_BP(VBP), .V_ACT(VA), .V_FP(VFP),
                     .PIPE_DELAY(0), .BLINK_BIT(5)) dut0 (
        .clk(clk), .clrn(clrn), .pixel_en(pixel_en),
        .h_addr(h_addr0), .v_addr(v_addr0), .valid(valid0),
        .hsync(hsync0), .vsync(vsync0),
        .hsync_d(hsync_d0), .vsync_d(vsync_d0), .valid_d(valid_d0),
        .frame_start(frame_start0), .frame_cnt(frame_cnt0), .blink(blink0));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       valid, hs, vs, hsd, vsd, vd, fs;
        logic [7:0] fc;
        logic       blink;
    } obs_t;

    typedef struct {
        int   cyc;
        int   tag;
        obs_t o;
    } ent_t;

    ent_t q[$];
    int   checks = 0, passes = 0, edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic string fmt(obs_t o);
        return $sformatf("h=%0d v=%0d val=%b hs=%b vs=%b hsd=%b vsd=%b vd=%b fs=%b fc=%0d bl=%b",
                         o.h, o.v, o.valid, o.hs, o.vs, o.hsd, o.vsd, o.vd, o.fs, o.fc, o.blink);
    endfunction

    // Monitor: pops every expectation stamped for the current clock cycle.
    ent_t me;
    obs_t act;
    always @(negedge clk) begin
        act = {h_addr, v_addr, valid, hsync, vsync, hsync_d, vsync_d, valid_d,
               frame_start, frame_cnt, blink};
        while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
            me = q.pop_front();
            checks++;
            if (me.cyc != edge_cnt)
                $display("FAIL stale cyc=%0d now=%0d", me.cyc, edge_cnt);
            else if (act !== me.o)
                $display("FAIL %s cyc=%0d actual: %s required: %s",
                         (me.tag == 0) ? "model" : "hand", me.cyc, fmt(act), fmt(me.o));
            else
                passes++;
            if (me.tag == 0) begin
                checks++;
                if ({hsync_d0, vsync_d0, valid_d0} !== {me.o.hs, me.o.vs, me.o.valid})
                    $display("FAIL pipe0 cyc=%0d actual=%b%b%b required=%b%b%b", me.cyc,
                             hsync_d0, vsync_d0, valid_d0, me.o.hs, me.o.vs, me.o.valid);
                else
                    passes++;
            end
        end
    end

    // Reference: t counts enabled edges since reset release.
    function automatic obs_t decode(int tt, logic fsv);
        obs_t o;
        int   p, h, v;
        logic [7:0] fc;
        o    = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (tt == 0) return o;
        p = (tt - 1) % FR;
        h = p % HT;
        v = p / HT;
        o.hs    = (h >= HS);
        o.vs    = (v >= VS);
        o.valid = (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
        if (o.valid) begin
            o.h = 10'(h - (HS + HBP));
            o.v = 10'(v - (VS + VBP));
        end
        fc      = 8'(((tt - 1) / FR + 1) % 256);
        o.fc    = fc;
        o.blink = fc[5];
        o.fs    = fsv;
        return o;
    endfunction

    int       t = 0;
    logic     fs_m = 1'b0, phase1 = 1'b0;
    logic [2:0] dh = 3'b111, dv = 3'b111, dd = 3'b000;
    obs_t     und;
    int       hand_t [6];
    obs_t     hand_o [6];

    task automatic cycle(input logic pen, input logic rl);
        obs_t o;
        @(posedge clk);
        #1;
        if (clrn) begin
            dh = {dh[1:0], und.hs};
            dv = {dv[1:0], und.vs};
            dd = {dd[1:0], und.valid};
            if (pixel_en) begin
                t++;
                fs_m = ((t - 1) % FR == 0);
            end else begin
                fs_m = 1'b0;
            end
        end
        clrn = rl;
        if (!rl) begin
            t = 0; fs_m = 1'b0; dh = 3'b111; dv = 3'b111; dd = 3'b000;
        end
        o     = decode(t, fs_m);
        o.hsd = dh[2];
        o.vsd = dv[2];
        o.vd  = dd[2];
        und   = o;
        q.push_back('{edge_cnt, 0, o});
        if (phase1) begin
            for (int i = 0; i < 6; i++)
                if (t == hand_t[i]) q.push_back('{edge_cnt, 1, hand_o[i]});
        end
        pixel_en = pen;
    endtask

    initial begin
        und = decode(0, 1'b0);
        und.hsd = 1'b1;
        und.vsd = 1'b1;
        //            h      v      val   hs    vs    hsd   vsd   vd    fs    fc     bl
        hand_t[0] = 1;     hand_o[0] = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1,  1'b0};
        hand_t[1] = 76;    hand_o[1] = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1,  1'b0};
        hand_t[2] = 134;   hand_o[2] = {10'd7, 10'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1,  1'b0};
        hand_t[3] = 154;   hand_o[3] = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2,  1'b0};
        hand_t[4] = 4744;  hand_o[4] = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd32, 1'b1};
        hand_t[5] = 39016; hand_o[5] = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0,  1'b0};

        phase1 = 1'b1;
        repeat (3) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        repeat (256 * FR + 2) cycle(1'b1, 1'b1);
        phase1 = 1'b0;

        // Half-rate pixel ticks across two frames.
        for (int i = 0; i < 4 * FR; i++) cycle(i[0], 1'b1);

        // Walk to a mid-line active position, then reset asynchronously.
        for (int i = 0; i < 2 * FR; i++) begin
            if (und.valid && und.h == 10'd2 && und.v == 10'd2) break;
            cycle(1'b1, 1'b1);
        end
        cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        repeat (2 * FR) cycle(1'b1, 1'b1);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0)
            $display("FAIL drain actual=%0d required=0", q.size());
        else
            passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator feeding the text/icon renderer that turns (h_addr, v_addr) into per-pixel ink flags.
- Produces the pixel address pair, the active-video flag, and sync pulses.
- Also produces copies of the syncs and active flag delayed to match the renderer's font-lookup pipeline, so colour and sync reach the DAC aligned.
- Provides a frame-start pulse, a frame counter and a blink bit for cursor/prompt flashing.

Parameters:
- H_SYNC, 96, hsync pulse width in pixel ticks
- H_BP, 48, horizontal back porch
- H_ACT, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch
- V_ACT, 480, visible lines
- V_FP, 10, vertical front porch
- PIPE_DELAY, 3, clk cycles of delay on the *_d outputs (legal range 0..7)
- BLINK_BIT, 5, frame_cnt bit driven on blink

Ports:
- clk  in  1  system clock, rising edge
- clrn  in  1  asynchronous active-low reset
- pixel_en  in  1  pixel tick qualifier; counters advance only on clk edges with pixel_en=1
- h_addr  out  10  visible column 0..H_ACT-1; 0 outside active video
- v_addr  out  10  visible row 0..V_ACT-1; 0 outside active video
- valid  out  1  1 while the decoded position is inside the active area
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- hsync_d  out  1  hsync delayed PIPE_DELAY clk cycles
- vsync_d  out  1  vsync delayed PIPE_DELAY clk cycles
- valid_d  out  1  valid delayed PIPE_DELAY clk cycles
- frame_start  out  1  one-clk pulse at start of each frame
- frame_cnt  out  8  frames elapsed since reset, modulo 256
- blink  out  1  frame_cnt[BLINK_BIT]

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOT-1 (H_TOT = sum of H params = 800); v_cnt runs 0..V_TOT-1 (V_TOT = 525).
  - On an enabled edge, h_cnt increments. At H_TOT-1 it wraps to 0 and v_cnt increments; v_cnt wraps from V_TOT-1 to 0.
  - pixel_en=0: counters and all undelayed outputs hold.
- Region order per line: sync [0, H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) = [144, 784), front porch. Vertical order is the same: active lines [35, 515).
- Output decode:
  - All undelayed outputs are registered decodes of the counter pair, updated on each enabled edge from the counter value held before that edge. Decoded outputs therefore lag the counters by one tick.
  - hsync = 0 iff h_cnt < H_SYNC; vsync = 0 iff v_cnt < V_SYNC.
  - valid = h active AND v active.
  - h_addr = h_cnt-144 and v_addr = v_cnt-35 when valid, else both 0.
  - Subtraction is performed at 10 bits; no wrap occurs within the legal range.
- Frame events:
  - frame_start is 1 for exactly one clk cycle, following the enabled edge that decodes (h_cnt, v_cnt) = (0, 0). It is 0 on every other cycle, including while pixel_en is low.
  - frame_cnt increments on that same edge and wraps 255 -> 0. blink follows frame_cnt combinationally.
- Delay line:
  - hsync_d, vsync_d and valid_d come from a PIPE_DELAY-deep shift register clocked every clk, independent of pixel_en.
  - PIPE_DELAY=0: each _d output equals its undelayed output.
- Reset (clrn=0, asynchronous, honoured at any time including mid-line or mid-frame):
  - h_cnt = v_cnt = 0; h_addr = v_addr = 0; valid = 0; hsync = vsync = 1; frame_start = 0; frame_cnt = 0; blink = 0.
  - All delay stages are cleared to valid=0 and sync=1.
  - After release, the first enabled edge decodes (0, 0): frame_start pulses, frame_cnt becomes 1, hsync and vsync go low.
- Simultaneous events: at a line wrap on the last line, the h wrap, the v wrap and the frame_start decode all occur on the same edge with no extra cycle.

Test Plan:
- Reset, then pixel_en=1 constantly -> hsync low for exactly 96 clk per 800-clk line; vsync low for exactly 1600 clk; frame_start period 420000 clk.
- Track the first valid cycle -> h_addr=0, v_addr=0 at decoded (144, 35). Last valid cycle -> h_addr=639, v_addr=479. valid high 640 clk per line on 480 lines only.
- Run 256 frames -> frame_cnt goes 1..255 then 0 and keeps counting; blink toggles every 32 frames.
- PIPE_DELAY=3 -> valid_d, hsync_d and vsync_d equal valid, hsync and vsync from exactly 3 clk earlier. With PIPE_DELAY=0 they are identical in the same cycle.
- pixel_en alternating 1/0 -> line length 1600 clk; outputs hold on pixel_en=0 cycles; frame_start still 1 clk wide.
- Assert clrn mid-line at h_addr=300, v_addr=200 -> all outputs take reset values with no clock edge required. After release, sequence restarts at (0, 0) with frame_cnt=1.
